// File: rtl/dmem_access_ctrl.sv
// Load/store front end for a word-wide combinational-read sram: byte/halfword/word
// accesses, read-modify-write for sub-word stores. Optional DMEM_MISALIGN_CHECK_EN flags misaligned accesses.
module dmem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state, state_nxt;
    logic              r_wr, r_sext, r_err;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_word;
    logic              misalign;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [DATA_W-1:0] load_val, merged;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            r_wr    <= 1'b0;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_word  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                r_wr    <= wr;
                r_size  <= size;
                r_sext  <= sext;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_err   <= misalign;
            end
            if (state == RD)
                r_word <= sram_dout;
        end
    end

    // Word stores skip the read; size 11 behaves as a word
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = misalign ? DONE : ((wr && size[1]) ? WR : RD);
            RD:   state_nxt = r_wr ? WR : DONE;
            WR:   state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_lane = r_word[{r_addr[1:0], 3'b000} +: 8];
        half_lane = r_addr[1] ? r_word[31:16] : r_word[15:0];
        case (r_size)
            2'b00:   load_val = {{(DATA_W-8){r_sext & byte_lane[7]}}, byte_lane};
            2'b01:   load_val = {{(DATA_W-16){r_sext & half_lane[15]}}, half_lane};
            default: load_val = r_word;
        endcase
        merged = r_word;
        if (r_size == 2'b00)
            merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else if (r_size == 2'b01)
            merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        else
            merged = r_wdata;
    end

    always_comb begin
        rdata     = '0;
        ready     = 1'b0;
        busy      = (state != IDLE);
        err       = 1'b0;
        sram_cs   = 1'b0;
        sram_oe   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        case (state)
            RD: begin
                sram_cs   = 1'b1;
                sram_oe   = 1'b1;
                sram_addr = {r_addr[ADDR_W-1:2], 2'b00};
            end
            WR: begin
                sram_cs   = 1'b1;
                sram_we   = 1'b1;
                sram_addr = {r_addr[ADDR_W-1:2], 2'b00};
                sram_din  = merged;
            end
            DONE: begin
                ready = 1'b1;
                rdata = (r_wr || r_err) ? '0 : load_val;
`ifdef DMEM_MISALIGN_CHECK_EN
                err   = r_err;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a small sram model and an expected-result queue.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, wr = 1'b0, sext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata, sram_addr, sram_din, sram_dout;
    logic        ready, busy, err, sram_cs, sram_oe, sram_we;

    int n_checks = 0, n_fail = 0, cyc = 0;
    logic [31:0] mem [0:255];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n_cs;
        int          n_we;
        logic [31:0] waddr;
        logic [31:0] wdin;
    } exp_t;
    exp_t sb[$];

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
        .err(err), .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sram_dout = mem[sram_addr[9:2]];
    always @(posedge clk) if (sram_cs && sram_we) mem[sram_addr[9:2]] <= sram_din;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        check("oe_we_excl", {31'b0, sram_oe & sram_we}, 32'h0);
        check("cs_idle_done", {31'b0, sram_cs & (~busy | ready)}, 32'h0);
    end

    task automatic access(input logic w, input logic [1:0] sz, input logic s,
                          input logic [31:0] a, input logic [31:0] wd, input logic pulse,
                          input exp_t ex, output int acc_cyc);
        exp_t e;
        int lat = 0, n_we = 0, n_cs = 0, guard = 0;
        bit acc = 0, got = 0;
        acc_cyc = -1;
        sb.push_back(ex);
        wr = w; size = sz; sext = s; addr = a; wdata = wd; req = 1'b1;
        while (!got && guard < 20) begin
            @(posedge clk); #1; guard++;
            if (!acc && busy) begin
                acc = 1; acc_cyc = cyc; lat = 1; req = pulse;
            end else if (acc) begin
                lat++; req = 1'b0;
            end
            if (sram_cs) n_cs++;
            if (sram_we) begin
                n_we++;
                check("wr_addr", sram_addr, sb[0].waddr);
                check("wr_din", sram_din, sb[0].wdin);
            end
            if (ready) begin
                got = 1;
                e = sb.pop_front();
                check("latency", lat, e.lat);
                check("rdata", rdata, e.rdata);
                check("err", {31'b0, err}, {31'b0, e.err});
                check("n_cs", n_cs, e.n_cs);
                check("n_we", n_we, e.n_we);
            end
        end
        req = 1'b0;
        if (!got) begin
            check("ready_timeout", 32'h0, 32'h1);
            void'(sb.pop_front());
        end
    endtask

    function automatic exp_t mk(logic [31:0] rd, logic er, int lat, int ncs, int nwe,
                                logic [31:0] wa, logic [31:0] wdn);
        exp_t e;
        e.rdata = rd; e.err = er; e.lat = lat; e.n_cs = ncs; e.n_we = nwe;
        e.waddr = wa; e.wdin = wdn;
        return e;
    endfunction

    initial begin
        int c0, c1, nready;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_ctl", {25'b0, ready, busy, err, sram_cs, sram_oe, sram_we, 1'b0}, 32'h0);
        check("rst_addr", sram_addr, 32'h0);
        check("rst_din", sram_din, 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", {31'b0, busy}, 32'h0);
        check("post_rst_cs", {31'b0, sram_cs}, 32'h0);

        // Abort a word store with reset while it is in its write cycle
        wr = 1'b1; size = 2'b10; addr = 32'h1000_0024; wdata = 32'hDEAD_BEEF; req = 1'b1;
        c0 = 0;
        while (!sram_we && c0 < 10) begin @(posedge clk); #1; c0++; end
        req = 1'b0;
        check("abort_saw_we", {31'b0, sram_we}, 32'h1);
        rst = 1'b1; #1;
        check("abort_we_drop", {30'b0, sram_we, sram_cs}, 32'h0);
        check("abort_idle", {30'b0, busy, ready}, 32'h0);
        @(negedge clk) rst = 1'b0;
        nready = 0;
        repeat (4) begin @(posedge clk); #1; if (ready) nready++; end
        check("abort_no_ready", nready, 0);

        access(1, 2'b10, 0, 32'h0040_003C, 32'h0000_000E, 0,
               mk(32'h0, 0, 2, 1, 1, 32'h0040_003C, 32'h0000_000E), c0);
        access(0, 2'b10, 0, 32'h0040_003C, 32'h0, 0,
               mk(32'h0000_000E, 0, 2, 1, 0, 32'h0, 32'h0), c0);

        access(1, 2'b10, 0, 32'h1000_0024, 32'h1122_3344, 0,
               mk(32'h0, 0, 2, 1, 1, 32'h1000_0024, 32'h1122_3344), c0);
        access(1, 2'b00, 0, 32'h1000_0026, 32'h0000_00AA, 0,
               mk(32'h0, 0, 3, 2, 1, 32'h1000_0024, 32'h11AA_3344), c0);
        access(0, 2'b10, 0, 32'h1000_0024, 32'h0, 0,
               mk(32'h11AA_3344, 0, 2, 1, 0, 32'h0, 32'h0), c0);

        access(1, 2'b10, 0, 32'h1000_0020, 32'h80FF_7F01, 0,
               mk(32'h0, 0, 2, 1, 1, 32'h1000_0020, 32'h80FF_7F01), c0);
        access(0, 2'b00, 1, 32'h1000_0021, 32'h0, 0, mk(32'h0000_007F, 0, 2, 1, 0, 0, 0), c0);
        access(0, 2'b00, 1, 32'h1000_0022, 32'h0, 0, mk(32'hFFFF_FFFF, 0, 2, 1, 0, 0, 0), c0);
        access(0, 2'b01, 0, 32'h1000_0022, 32'h0, 0, mk(32'h0000_80FF, 0, 2, 1, 0, 0, 0), c0);
        access(0, 2'b01, 1, 32'h1000_0022, 32'h0, 0, mk(32'hFFFF_80FF, 0, 2, 1, 0, 0, 0), c0);
        access(0, 2'b00, 0, 32'h1000_0023, 32'h0, 0, mk(32'h0000_0080, 0, 2, 1, 0, 0, 0), c0);
        access(0, 2'b01, 1, 32'h1000_0020, 32'h0, 0, mk(32'h0000_7F01, 0, 2, 1, 0, 0, 0), c0);

        // Halfword store into the upper lane keeps the lower lane
        access(1, 2'b01, 0, 32'h0040_003E, 32'h1234_ABCD, 0,
               mk(32'h0, 0, 3, 2, 1, 32'h0040_003C, 32'hABCD_000E), c0);

        // Extra req while busy must not start a second sequence
        access(0, 2'b10, 0, 32'h1000_0020, 32'h0, 1, mk(32'h80FF_7F01, 0, 2, 1, 0, 0, 0), c0);
        nready = 0;
        repeat (4) begin @(posedge clk); #1; if (ready || busy) nready++; end
        check("busy_req_ignored", nready, 0);

        access(0, 2'b00, 0, 32'h1000_0024, 32'h0, 0, mk(32'h0000_0044, 0, 2, 1, 0, 0, 0), c0);
        access(0, 2'b00, 0, 32'h1000_0025, 32'h0, 0, mk(32'h0000_0033, 0, 2, 1, 0, 0, 0), c1);
        check("b2b_spacing", c1 - c0, 3);

        access(1, 2'b10, 0, 32'hFFFF_FFFC, 32'h0, 0,
               mk(32'h0, 0, 2, 1, 1, 32'hFFFF_FFFC, 32'h0), c0);
        access(1, 2'b00, 0, 32'hFFFF_FFFF, 32'h0000_005C, 0,
               mk(32'h0, 0, 3, 2, 1, 32'hFFFF_FFFC, 32'h5C00_0000), c0);
        access(0, 2'b00, 1, 32'hFFFF_FFFF, 32'h0, 0, mk(32'h0000_005C, 0, 2, 1, 0, 0, 0), c0);

        access(1, 2'b10, 0, 32'h0040_0050, 32'hCAFE_F00D, 0,
               mk(32'h0, 0, 2, 1, 1, 32'h0040_0050, 32'hCAFE_F00D), c0);
`ifdef DMEM_MISALIGN_CHECK_EN
        access(0, 2'b10, 0, 32'h0040_0052, 32'h0, 0, mk(32'h0, 1, 1, 0, 0, 0, 0), c0);
        access(1, 2'b01, 0, 32'h0040_0051, 32'h0000_1111, 0, mk(32'h0, 1, 1, 0, 0, 0, 0), c0);
        access(0, 2'b10, 0, 32'h0040_0050, 32'h0, 0, mk(32'hCAFE_F00D, 0, 2, 1, 0, 0, 0), c0);
`else
        access(0, 2'b10, 0, 32'h0040_0052, 32'h0, 0, mk(32'hCAFE_F00D, 0, 2, 1, 0, 0, 0), c0);
        access(0, 2'b01, 0, 32'h0040_0053, 32'h0, 0, mk(32'h0000_CAFE, 0, 2, 1, 0, 0, 0), c0);
`endif

        @(posedge clk); #1;
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sits between the processor's load/store path and the word-wide sram.
- Converts byte, halfword and word loads/stores into sram cs/oe/we cycles.
- Sub-word stores use a read-modify-write sequence; loads are aligned and zero/sign-extended.
- Presents a req/ready handshake to the core and keeps sram control lines deasserted when idle.

Parameters:
- ADDR_W, 32, width of byte address on both sides
- DATA_W, 32, sram word width (fixed 32; other values unsupported)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- req  input  1  access request, sampled only in IDLE
- wr  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- sext  input  1  sign-extend sub-word loads when 1
- addr  input  ADDR_W  byte address
- wdata  input  DATA_W  store data, right-aligned
- rdata  output  DATA_W  load result, valid while ready=1
- ready  output  1  one-cycle completion pulse
- busy  output  1  high in every state except IDLE
- err  output  1  misaligned-access flag (see Optional Feature)
- sram_cs  output  1  to sram cs
- sram_oe  output  1  to sram oe
- sram_we  output  1  to sram we
- sram_addr  output  ADDR_W  word-aligned address, bits [1:0] = 00
- sram_din  output  DATA_W  write word to sram
- sram_dout  input  DATA_W  read word from sram (combinational read)

Behaviour:
- Reset: FSM in IDLE. All outputs are 0: rdata, ready, busy, err, sram_cs/oe/we, sram_addr, sram_din. Latched request registers are cleared.
- Byte order is little-endian: byte lane k = bits [8k+7:8k] for addr[1:0]=k. Halfword lane = addr[1].
- States are IDLE, RD, WR, DONE.
- Request acceptance in IDLE: when req=1, latch wr, size, sext, addr, wdata.
  - Load or sub-word store -> RD.
  - Word store -> WR.
- req while busy is ignored. The core must hold req until ready, or re-issue it.
- RD (1 cycle):
  - Drive cs=1, oe=1, we=0, sram_addr = {addr[31:2],2'b00}.
  - Capture sram_dout at the clock edge.
  - Load -> DONE. Store -> WR.
- WR (1 cycle):
  - Drive cs=1, oe=0, we=1.
  - Word store: din = wdata.
  - Sub-word store: din = captured word with the addressed lane replaced by wdata[7:0] or wdata[15:0]; other lanes unchanged.
  - -> DONE.
- DONE (1 cycle):
  - cs/oe/we = 0.
  - ready=1.
  - rdata is the extracted lane, zero-extended, or sign-extended when sext=1. For stores, rdata = 0.
  - -> IDLE.
- Latency from the req-sampling edge to ready high:
  - load = 2 cycles
  - word store = 2 cycles
  - sub-word store = 3 cycles
- Back-to-back: the next req is accepted in the IDLE cycle after DONE, so the minimum request spacing is 3 cycles.
- sram_cs is never high in IDLE or DONE. oe and we are never both high.
- Reset mid-operation:
  - Asynchronously forces IDLE and drops cs/we in the same instant.
  - An aborted WR leaves memory undefined only at that word.
  - No ready pulse is issued.
- Address wrap: addr 0xFFFFFFFF with size=byte accesses word 0xFFFFFFFC, lane 3. No overflow handling is needed.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]≠00, goes IDLE -> DONE directly with no sram cycle.
  - In DONE: ready=1, err=1, rdata=0. err is a one-cycle pulse coincident with ready.
- Undefined:
  - err is tied 0.
  - Misaligned low bits are ignored: halfword uses addr[1], word uses lane 0.
  - The access proceeds normally.

Test Plan:
- Reset held, then released -> all outputs 0, busy=0. Assert rst during WR of a store to 0x10000024 -> sram_we drops immediately, FSM in IDLE, no ready.
- Word store wdata=0x0000000E to 0x0040003C, then word load of the same address -> WR cycle shows sram_addr=0x0040003C, din=0x0000000E. Load returns rdata=0x0000000E, ready 2 cycles after req.
- Word 0x11223344 at 0x10000024; byte store 0xAA to 0x10000026 -> RD, WR, DONE sequence. Written word = 0x11AA3344, ready 3 cycles after req.
- Word 0x80FF7F01 at 0x10000020:
  - byte load at 0x10000021, sext=1 -> 0x0000007F
  - byte load at 0x10000022, sext=1 -> 0xFFFFFFFF
  - halfword load at 0x10000022, sext=0 -> 0x000080FF
- req pulsed while busy=1 -> ignored: one sram sequence, one ready pulse. Back-to-back loads are accepted with 3-cycle spacing.
- With DMEM_MISALIGN_CHECK_EN, word load at 0x00400052 -> ready=1 and err=1 one cycle after req, sram_cs stays 0. Without the macro -> reads 0x00400050, err=0.
